// File: rtl/quad_encoder_gen.sv
// Rotary-encoder emulator: walks gray-coded quadrature A/B one step per STEP_CYCLES
// clocks until the emitted position matches the loaded target.
module quad_encoder_gen #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] target,
  output logic             enc_a,
  output logic             enc_b,
  output logic [WIDTH-1:0] position,
  output logic             busy,
  output logic             done
);

  localparam int unsigned TW = $clog2(STEP_CYCLES) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(STEP_CYCLES - 1);

  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] position_q, position_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       phase_q, phase_d;
  logic             enc_a_q, enc_a_d;
  logic             enc_b_q, enc_b_d;
  logic             done_q, done_d;
  logic             busy_c;
  logic             step_c;

  assign busy_c = (position_q != target_q);

  // Phase index 0..3 maps to AB 00,10,11,01; up steps increment the index.
  always_comb begin
    target_d   = target_q;
    position_d = position_q;
    timer_d    = '0;
    phase_d    = phase_q;
    step_c     = 1'b0;

    if (busy_c) begin
      if (timer_q == T_LAST) begin
        step_c = 1'b1;
        if (target_q > position_q) begin
          position_d = position_q + WIDTH'(1);
          phase_d    = phase_q + 2'd1;
        end else begin
          position_d = position_q - WIDTH'(1);
          phase_d    = phase_q - 2'd1;
        end
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    if (load) begin
      target_d = target;
    end

    enc_a_d = phase_d[1] ^ phase_d[0];
    enc_b_d = phase_d[1];
    done_d  = (position_d == target_d) && (step_c || load);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q   <= '0;
      position_q <= '0;
      timer_q    <= '0;
      phase_q    <= '0;
      enc_a_q    <= 1'b0;
      enc_b_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      target_q   <= target_d;
      position_q <= position_d;
      timer_q    <= timer_d;
      phase_q    <= phase_d;
      enc_a_q    <= enc_a_d;
      enc_b_q    <= enc_b_d;
      done_q     <= done_d;
    end
  end

  assign enc_a    = enc_a_q;
  assign enc_b    = enc_b_q;
  assign position = position_q;
  assign busy     = busy_c;
  assign done     = done_q;

endmodule
